// File: rtl/plab3_mem_tdm_mem_arbiter.sv
// Two-domain TDM memory arbiter: fixed alternating slots, one outstanding transaction,
// one-entry response buffer per cache. Optional PLAB3_MEM_TDM_ARB_WORK_CONSERVE_EN lets
// the non-owner use an unclaimed slot (breaks timing isolation).
module plab3_mem_tdm_mem_arbiter #(
  parameter int unsigned p_opaque_nbits = 8,
  parameter int unsigned p_slot_cycles  = 8,
  parameter int unsigned abw            = 32,
  parameter int unsigned clw            = 128,
  localparam int unsigned LenNbits  = $clog2(clw / 8),
  localparam int unsigned ReqNbits  = 3 + p_opaque_nbits + abw + LenNbits + clw,
  localparam int unsigned RespNbits = 3 + p_opaque_nbits + 2 + LenNbits + clw
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [ReqNbits-1:0]  c0_memreq_msg_i,
  input  logic                 c0_memreq_val_i,
  output logic                 c0_memreq_rdy_o,
  output logic [RespNbits-1:0] c0_memresp_msg_o,
  output logic                 c0_memresp_val_o,
  input  logic                 c0_memresp_rdy_i,
  input  logic [ReqNbits-1:0]  c1_memreq_msg_i,
  input  logic                 c1_memreq_val_i,
  output logic                 c1_memreq_rdy_o,
  output logic [RespNbits-1:0] c1_memresp_msg_o,
  output logic                 c1_memresp_val_o,
  input  logic                 c1_memresp_rdy_i,
  output logic [ReqNbits-1:0]  memreq_msg_o,
  output logic                 memreq_val_o,
  input  logic                 memreq_rdy_i,
  input  logic [RespNbits-1:0] memresp_msg_i,
  input  logic                 memresp_val_i,
  output logic                 memresp_rdy_o,
  output logic                 slot_owner_o,
  output logic                 overrun_o
);

  localparam int unsigned CtrW = $clog2(p_slot_cycles);

  typedef enum logic {StIdle, StWait} state_e;

  state_e              state_q, state_d;
  logic [CtrW-1:0]     slot_ctr_q;
  logic                slot_owner_q;
  logic                issuer_q, issuer_d;
  logic                overrun_q, overrun_d;
  logic [1:0]          full_q, full_d;
  logic [RespNbits-1:0] buf0_q, buf1_q;

  logic       slot_start, slot_wrap;
  logic [1:0] elig;
  logic [1:0] resp_rdy;
  logic       issue_val, issue_port;
  logic       resp_fire;

  assign slot_start = (slot_ctr_q == '0);
  assign slot_wrap  = (slot_ctr_q == CtrW'(p_slot_cycles - 1));
  assign resp_rdy   = {c1_memresp_rdy_i, c0_memresp_rdy_i};
  // A full buffer makes its own port ineligible but never affects the other port.
  assign elig       = {c1_memreq_val_i & ~full_q[1], c0_memreq_val_i & ~full_q[0]};
  assign resp_fire  = (state_q == StWait) & memresp_val_i;

  always_comb begin
    issue_val  = 1'b0;
    issue_port = slot_owner_q;
    if (!reset_i && state_q == StIdle && slot_start) begin
      if (elig[slot_owner_q]) begin
        issue_val = 1'b1;
      end
`ifdef PLAB3_MEM_TDM_ARB_WORK_CONSERVE_EN
      else if (elig[~slot_owner_q]) begin
        issue_val  = 1'b1;
        issue_port = ~slot_owner_q;
      end
`endif
    end
  end

  assign memreq_val_o     = issue_val;
  assign memreq_msg_o     = issue_port ? c1_memreq_msg_i : c0_memreq_msg_i;
  assign c0_memreq_rdy_o  = issue_val & ~issue_port & memreq_rdy_i;
  assign c1_memreq_rdy_o  = issue_val & issue_port & memreq_rdy_i;
  assign memresp_rdy_o    = (state_q == StWait) & ~reset_i;
  assign c0_memresp_val_o = full_q[0];
  assign c1_memresp_val_o = full_q[1];
  assign c0_memresp_msg_o = buf0_q;
  assign c1_memresp_msg_o = buf1_q;
  assign slot_owner_o     = slot_owner_q;
  assign overrun_o        = overrun_q;

  always_comb begin
    state_d   = state_q;
    issuer_d  = issuer_q;
    overrun_d = overrun_q;
    full_d    = full_q & ~resp_rdy;
    unique case (state_q)
      StIdle: begin
        if (issue_val && memreq_rdy_i) begin
          state_d  = StWait;
          issuer_d = issue_port;
        end
      end
      StWait: begin
        if (memresp_val_i) begin
          state_d          = StIdle;
          full_d[issuer_q] = 1'b1;
        end else if (slot_wrap) begin
          // Still waiting as the slot ends: the memory exceeded the slot budget.
          overrun_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      slot_ctr_q   <= '0;
      slot_owner_q <= 1'b0;
      issuer_q     <= 1'b0;
      overrun_q    <= 1'b0;
      full_q       <= '0;
      buf0_q       <= '0;
      buf1_q       <= '0;
    end else begin
      state_q    <= state_d;
      slot_ctr_q <= slot_ctr_q + CtrW'(1);
      if (slot_wrap) begin
        slot_owner_q <= ~slot_owner_q;
      end
      issuer_q  <= issuer_d;
      overrun_q <= overrun_d;
      full_q    <= full_d;
      if (resp_fire && !issuer_q) begin
        buf0_q <= memresp_msg_i;
      end
      if (resp_fire && issuer_q) begin
        buf1_q <= memresp_msg_i;
      end
    end
  end

endmodule

// File: tb/tb_plab3_mem_tdm_mem_arbiter.sv
// Bench for plab3_mem_tdm_mem_arbiter: directed slot scenarios plus a random phase, all
// checked cycle by cycle against a slot-arithmetic reference model.
module tb_plab3_mem_tdm_mem_arbiter;

  localparam int Slot  = 8;
  localparam int ReqW  = 175;
  localparam int RespW = 145;

  logic             clk, reset;
  logic [ReqW-1:0]  c0_memreq_msg, c1_memreq_msg, memreq_msg;
  logic             c0_memreq_val, c0_memreq_rdy, c1_memreq_val, c1_memreq_rdy;
  logic [RespW-1:0] c0_memresp_msg, c1_memresp_msg, memresp_msg;
  logic             c0_memresp_val, c0_memresp_rdy, c1_memresp_val, c1_memresp_rdy;
  logic             memreq_val, memreq_rdy, memresp_val, memresp_rdy;
  logic             slot_owner, overrun;

  plab3_mem_tdm_mem_arbiter dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .c0_memreq_msg_i  (c0_memreq_msg),
    .c0_memreq_val_i  (c0_memreq_val),
    .c0_memreq_rdy_o  (c0_memreq_rdy),
    .c0_memresp_msg_o (c0_memresp_msg),
    .c0_memresp_val_o (c0_memresp_val),
    .c0_memresp_rdy_i (c0_memresp_rdy),
    .c1_memreq_msg_i  (c1_memreq_msg),
    .c1_memreq_val_i  (c1_memreq_val),
    .c1_memreq_rdy_o  (c1_memreq_rdy),
    .c1_memresp_msg_o (c1_memresp_msg),
    .c1_memresp_val_o (c1_memresp_val),
    .c1_memresp_rdy_i (c1_memresp_rdy),
    .memreq_msg_o     (memreq_msg),
    .memreq_val_o     (memreq_val),
    .memreq_rdy_i     (memreq_rdy),
    .memresp_msg_i    (memresp_msg),
    .memresp_val_i    (memresp_val),
    .memresp_rdy_o    (memresp_rdy),
    .slot_owner_o     (slot_owner),
    .overrun_o        (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Environment controls
  logic [1:0]       req_pend;
  logic [ReqW-1:0]  req_msg [2];
  logic [1:0]       rsp_rdy;
  logic             mreq_rdy;
  int               lat;
  bit               noise;
  // Memory model
  bit               mem_pend;
  int               mem_due;
  logic [RespW-1:0] mem_msg;
  // Reference model state
  int               t;
  bit               busy, ovr;
  int               issuer;
  logic [1:0]       full;
  logic [RespW-1:0] rbuf [2];
  // Event log from DUT observations
  int acc [2];
  int rv [2];
  int first_mreq, first_ovr;

  function automatic logic [191:0] rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [RespW-1:0] mk_resp(logic [ReqW-1:0] rq);
    logic [191:0] r;
    r = rnd();
    return {rq[174:164], 2'b00, rq[131:128], r[127:0]};
  endfunction

  task automatic chk(string tag, logic [191:0] obs, logic [191:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  task automatic new_req(int p);
    logic [191:0] r;
    r = rnd();
    req_pend[p] = 1'b1;
    req_msg[p]  = r[ReqW-1:0];
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_memreq_val", memreq_val, 0);
    chk("rst_c0_rdy", c0_memreq_rdy, 0);
    chk("rst_c1_rdy", c1_memreq_rdy, 0);
    chk("rst_memresp_rdy", memresp_rdy, 0);
    chk("rst_c0_resp_val", c0_memresp_val, 0);
    chk("rst_c1_resp_val", c1_memresp_val, 0);
    chk("rst_slot_owner", slot_owner, 0);
    chk("rst_overrun", overrun, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    t = 0; busy = 0; ovr = 0; issuer = 0; full = '0;
    req_pend = '0; mem_due = 0;
    acc[0] = -1; acc[1] = -1; rv[0] = -1; rv[1] = -1;
    first_mreq = -1; first_ovr = -1;
  endtask

  // One clock cycle: drive, predict, compare at negedge, then advance the model.
  task automatic step();
    int ctr, own, ip;
    bit iv, mem_now;
    logic [1:0] nfull;
    logic [191:0] r;
    ctr = t % Slot;
    own = (t / Slot) % 2;
    r = rnd();
    c0_memreq_val  = req_pend[0];
    c0_memreq_msg  = req_msg[0];
    c1_memreq_val  = req_pend[1];
    c1_memreq_msg  = req_msg[1];
    c0_memresp_rdy = rsp_rdy[0];
    c1_memresp_rdy = rsp_rdy[1];
    memreq_rdy     = mreq_rdy;
    mem_now = mem_pend && (t >= mem_due);
    if (mem_now) begin
      memresp_val = 1'b1;
      memresp_msg = mem_msg;
    end else begin
      memresp_val = noise && !busy && ($urandom_range(0, 3) == 0);
      memresp_msg = r[RespW-1:0];
    end
    iv = 0;
    ip = own;
    if (!busy && ctr == 0) begin
      if (req_pend[own] && !full[own]) iv = 1;
`ifdef PLAB3_MEM_TDM_ARB_WORK_CONSERVE_EN
      else if (req_pend[1-own] && !full[1-own]) begin
        iv = 1;
        ip = 1 - own;
      end
`endif
    end
    #4;
    chk("memreq_val", memreq_val, iv);
    if (iv) chk("memreq_msg", memreq_msg, req_msg[ip]);
    chk("c0_memreq_rdy", c0_memreq_rdy, iv && ip == 0 && mreq_rdy);
    chk("c1_memreq_rdy", c1_memreq_rdy, iv && ip == 1 && mreq_rdy);
    chk("memresp_rdy", memresp_rdy, busy);
    chk("c0_memresp_val", c0_memresp_val, full[0]);
    chk("c1_memresp_val", c1_memresp_val, full[1]);
    if (full[0]) chk("c0_memresp_msg", c0_memresp_msg, rbuf[0]);
    if (full[1]) chk("c1_memresp_msg", c1_memresp_msg, rbuf[1]);
    chk("slot_owner", slot_owner, own);
    chk("overrun", overrun, ovr);
    if (c0_memreq_val && c0_memreq_rdy && acc[0] < 0) acc[0] = t;
    if (c1_memreq_val && c1_memreq_rdy && acc[1] < 0) acc[1] = t;
    if (c0_memresp_val && rv[0] < 0) rv[0] = t;
    if (c1_memresp_val && rv[1] < 0) rv[1] = t;
    if (memreq_val && first_mreq < 0) first_mreq = t;
    if (overrun && first_ovr < 0) first_ovr = t;
    @(posedge clk);
    #1;
    nfull = full & ~rsp_rdy;
    if (busy && memresp_val) begin
      nfull[issuer] = 1'b1;
      rbuf[issuer]  = memresp_msg;
      busy = 0;
      if (mem_now) mem_pend = 0;
    end else if (busy && ctr == Slot - 1) begin
      ovr = 1;
    end
    if (iv && mreq_rdy) begin
      busy = 1;
      issuer = ip;
      req_pend[ip] = 1'b0;
      mem_pend = 1;
      mem_due = t + lat;
      mem_msg = mk_resp(req_msg[ip]);
    end
    full = nfull;
    t++;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    req_pend = '0; rsp_rdy = 2'b11; mreq_rdy = 1'b1; lat = 3; noise = 0; mem_pend = 0;
    req_msg[0] = '0; req_msg[1] = '0;
    reset = 1'b0;
    c0_memreq_val = 1'b1; c1_memreq_val = 1'b1;
    c0_memreq_msg = '0; c1_memreq_msg = '0; c0_memresp_rdy = 1'b1; c1_memresp_rdy = 1'b1;
    memreq_rdy = 1'b1; memresp_val = 1'b0; memresp_msg = '0;

    // Basic read with competing c1 traffic held from cycle 0
    do_reset();
    new_req(0); new_req(1); lat = 3;
    run(12);
    chk("d1_c0_issue", acc[0], 0);
    chk("d1_c0_resp", rv[0], 4);
    chk("d1_c1_issue", acc[1], 8);

    // Same c0 read without c1 traffic: identical timing
    do_reset();
    new_req(0);
    run(8);
    chk("d1b_c0_resp", rv[0], 4);

    // Request raised mid-slot waits for the next owned slot start
    do_reset();
    run(1);
    new_req(0);
    run(17);
    chk("d2_first_memreq", first_mreq, 16);
    chk("d2_c0_issue", acc[0], 16);

    // Memory not ready at slot start: slot forfeited
    do_reset();
    new_req(0); mreq_rdy = 1'b0;
    run(1);
    mreq_rdy = 1'b1;
    run(17);
    chk("d3_c0_issue", acc[0], 16);

    // Slow memory: overrun at the first wrap, c1 slot lost
    do_reset();
    new_req(0); new_req(1); lat = 10;
    run(20);
    chk("d4_first_ovr", first_ovr, 8);
    chk("d4_c1_not_issued", acc[1], -1);
    chk("d4_ovr_sticky", overrun, 1);

    // Full c0 buffer blocks c0 only; then reset mid-WAIT with the memory still replying
    do_reset();
    rsp_rdy = 2'b10; lat = 2;
    new_req(0); new_req(1);
    run(4);
    chk("d5_c0_buf_full", c0_memresp_val, 1);
    new_req(0);
    acc[0] = -1; lat = 5;
    run(6);
    chk("d5_c1_issue", acc[1], 8);
    chk("d5_c0_blocked", acc[0], -1);
    do_reset();
    rsp_rdy = 2'b11;
    run(3);
    mem_pend = 0;
    chk("d5_post_rst_buf", c1_memresp_val, 0);
    run(2);

    // Owner idle at slot start
    do_reset();
    new_req(1); lat = 2;
    run(10);
`ifdef PLAB3_MEM_TDM_ARB_WORK_CONSERVE_EN
    chk("d6_c1_issue", acc[1], 0);
`else
    chk("d6_c1_issue", acc[1], 8);
`endif

    // Random traffic within the slot latency budget
    do_reset();
    noise = 1;
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!req_pend[p] && $urandom_range(0, 3) == 0) new_req(p);
      end
      rsp_rdy  = 2'($urandom_range(0, 3));
      mreq_rdy = ($urandom_range(0, 7) != 0);
      lat      = $urandom_range(1, 6);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
